// File: rtl/serial_polyshift_r.sv
// Serial barrel-shift replacement: shifts one bit per cycle in four modes
// (logic, arithmetic, carry-extended, rotate) behind a start/ready, valid/ready pair.
module serial_polyshift_r #(
    parameter int word_width = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    output logic                          ready,
    input  logic [word_width-1:0]         D_IN,
    input  logic [word_width-2:0]         C_IN,
    input  logic [$clog2(word_width)-1:0] shift_size,
    input  logic [1:0]                    shift_type,
    output logic [word_width-1:0]         D_OUT,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          busy
);

    localparam int SW = $clog2(word_width);

    localparam logic [1:0] T_LOGIC = 2'd0;
    localparam logic [1:0] T_ARITH = 2'd1;
    localparam logic [1:0] T_CARRY = 2'd2;
    localparam logic [1:0] T_ROT   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [word_width-1:0] r_d;
    logic [word_width-2:0] r_c;
    logic [SW-1:0]         r_cnt;
    logic [1:0]            r_type;
    logic [word_width-1:0] r_dout;
    logic                  r_out_valid;
    logic                  r_busy;
    logic                  r_ready;

    logic                  w_fill;
    logic [word_width-1:0] w_next;

    // Bit entering the MSB on each single-bit step.
    always_comb begin
        w_fill = 1'b0;
        unique case (r_type)
            T_LOGIC: w_fill = 1'b0;
            T_ARITH: w_fill = r_d[word_width-1];
            T_CARRY: w_fill = r_c[0];
            T_ROT:   w_fill = r_d[0];
        endcase
        w_next = {w_fill, r_d[word_width-1:1]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_d         <= '0;
            r_c         <= '0;
            r_cnt       <= '0;
            r_type      <= T_LOGIC;
            r_dout      <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_ready     <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_d     <= D_IN;
                        r_c     <= C_IN;
                        r_cnt   <= shift_size;
                        r_type  <= shift_type;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        if (shift_size == '0) begin
                            r_dout      <= D_IN;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_state <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    r_d   <= w_next;
                    r_c   <= r_c >> 1;
                    r_cnt <= r_cnt - 1'b1;
                    // Last step: publish the result on the same edge.
                    if (r_cnt == SW'(1)) begin
                        r_dout      <= w_next;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_ready     <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_ready     <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign ready     = r_ready;
    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign D_OUT     = r_dout;

endmodule

// File: doc/serial_polyshift_r.md
SERIAL_POLYSHIFT_R -- requirements
Module: serial_polyshift_r

Interface
REQ-001 SHALL have parameter word_width, default 8: data width in bits, minimum 4, power of two.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: request valid; accepted when start && ready.
REQ-005 SHALL have port ready, output, 1: block idle and able to accept a request.
REQ-006 SHALL have port D_IN, input, word_width: operand to shift right.
REQ-007 SHALL have port C_IN, input, word_width-1: extension bits for carry mode.
REQ-008 SHALL have port shift_size, input, $clog2(word_width): shift distance, 0..word_width-1.
REQ-009 SHALL have port shift_type, input, SHIFT_TYPE: 0 LOGIC, 1 ARITH, 2 carry-extended, 3 rotate.
REQ-010 SHALL have port D_OUT, output, word_width: shift result.
REQ-011 SHALL have port out_valid, output, 1: D_OUT holds a completed result.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts the result when out_valid && out_ready.
REQ-013 SHALL have port busy, output, 1: high in SHIFT and DONE states.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-015 In IDLE: ready=1, busy=0, out_valid=0.
REQ-016 On start && ready, SHALL register D_IN, C_IN, shift_size and shift_type in the same edge.
- Registered operands only are used afterwards; input changes after acceptance have no effect.
REQ-017 Accept with shift_size=0 SHALL go to DONE, result = D_IN.
- Accept with shift_size>0 SHALL go to SHIFT, counter = shift_size.
REQ-018 In SHIFT, SHALL shift the working value right by exactly one bit per cycle and decrement the counter.
- When the counter reaches 0, SHALL go to DONE.
REQ-019 Latency SHALL be shift_size+1 cycles from the accept edge to out_valid=1: size 0 gives out_valid in cycle 1, size 7 in cycle 8.
REQ-020 LOGIC: result = D_IN >> n, zero fill.
REQ-021 ARITH: result = D_IN >> n, fill with D_IN[word_width-1].
REQ-022 Carry-extended: result = low word_width bits of {1'b0, C_IN, D_IN} >> n.
- Bits enter from C_IN, LSB first.
REQ-023 Rotate: result = D_IN rotated right by n; bits leaving bit 0 enter bit word_width-1.
REQ-024 In DONE: out_valid=1 and D_OUT holds the result.
- D_OUT SHALL be stable while out_ready=0 for any number of cycles.
REQ-025 On out_valid && out_ready, SHALL return to IDLE on that edge; ready=1 in the following cycle.
- No same-cycle re-accept.
REQ-026 start while busy SHALL be ignored; no queuing, no effect on the operation in flight.
REQ-027 D_OUT SHALL retain the last result in IDLE until the next result completes.
REQ-028 Undefined shift_type values: none exist; all four encodings are legal.

Reset
REQ-029 reset=1 at a clock edge SHALL force IDLE, D_OUT=0, out_valid=0, busy=0, ready=1 and counter=0, overriding all other inputs.
REQ-030 Reset asserted mid-SHIFT or in DONE SHALL abort the operation; no out_valid pulse follows.

Verification (word_width=8)
REQ-031 LOGIC: D=10110110, size 3 -> D_OUT=00010110, out_valid in cycle 4 after accept.
- ARITH, same D and size -> D_OUT=11110110.
REQ-032 Carry-extended: D=10110110, C=1010011, size 3 -> D_OUT=01110110.
- Rotate, D=10110110, size 3 -> D_OUT=11010110.
REQ-033 Size 0, any type, D=10110110 -> D_OUT=10110110 with out_valid in cycle 1.
- Size 7 ARITH, D=10000000 -> D_OUT=11111111 in cycle 8.
REQ-034 out_ready held 0 for 5 cycles in DONE -> out_valid and D_OUT stable.
- start pulsed with new operands during SHIFT -> ignored; original result delivered.
REQ-035 reset pulsed in SHIFT cycle 2 of a size-5 shift -> next cycle IDLE, D_OUT=0, ready=1, and no out_valid.
- A new request is then accepted and completes correctly.
REQ-036 Exhaustive sweep: all 4 types x sizes 0..7 x random D/C SHALL match the REQ-020..023 reference model, including latency.
